// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the Gaussian convolution engine.
package conv_pkg;

    // Engine control states.
    typedef enum logic [2:0] {
        IDLE,
        TRANS,
        WAIT_RDY,
        REQ,
        MAC,
        DRAIN,
        WRITE,
        DONE
    } state_t;

    // Window traversal directions used by the window/position producer.
    typedef enum logic [1:0] {
        RIGHT = 2'd0,
        LEFT  = 2'd1,
        DOWN  = 2'd2,
        DOWN2 = 2'd3
    } dir_t;

    // Accumulator width that holds k*k full-scale products without overflow.
    function automatic int acc_width(input int pix_w, input int wgt_w, input int max_k);
        return pix_w + wgt_w + 2 * $clog2(max_k);
    endfunction

    localparam int ACC_W_DEFAULT = acc_width(8, 8, 31);

endpackage

// File: rtl/conv_mac.sv
// Multiply-accumulate datapath: clear, enabled product add, saturating normalisation.
module conv_mac
    import conv_pkg::*;
#(
    parameter int PIXEL_DEPTH  = 8,
    parameter int WEIGHT_DEPTH = 8,
    parameter int ACC_W        = ACC_W_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr_i,
    input  logic                    en_i,
    input  logic [PIXEL_DEPTH-1:0]  pix_i,
    input  logic [WEIGHT_DEPTH-1:0] wgt_i,
    input  logic [4:0]              shift_i,
    output logic [PIXEL_DEPTH-1:0]  sat_o
);

    localparam logic [ACC_W-1:0] PIX_MAX = ACC_W'({PIXEL_DEPTH{1'b1}});

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] shifted;

    // Next accumulator value: clear wins over accumulate.
    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + ACC_W'(pix_i) * ACC_W'(wgt_i);
        end
    end

    // Accumulator register.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // Normalise and clamp to the pixel range.
    always_comb begin
        shifted = acc_q >> shift_i;
        sat_o   = (shifted > PIX_MAX) ? {PIXEL_DEPTH{1'b1}} : shifted[PIXEL_DEPTH-1:0];
    end

endmodule

// File: rtl/gauss_conv_engine.sv
// Gaussian convolution engine: per raster position, snapshot a k x k window,
// stream k*k weights from SRAM through the MAC and write one filtered pixel.
module gauss_conv_engine
    import conv_pkg::*;
#(
    parameter int MAX_KERNEL   = 31,
    parameter int X_MAX        = 60,
    parameter int Y_MAX        = 60,
    parameter int PIXEL_DEPTH  = 8,
    parameter int WEIGHT_DEPTH = 8
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic                                                 start,
    input  logic [$clog2(MAX_KERNEL)-1:0]                        kernel_size,
    input  logic [4:0]                                           norm_shift,
    output logic                                                 done,
    output logic                                                 new_trans,
    output logic                                                 new_sample_req,
    input  logic                                                 new_sample_ready,
    input  logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][PIXEL_DEPTH-1:0] working_memory,
    output logic                                                 update_pos,
    input  logic [$clog2(X_MAX)-1:0]                             curr_x,
    input  logic [$clog2(Y_MAX)-1:0]                             curr_y,
    input  logic                                                 end_pos,
    output logic [$clog2(MAX_KERNEL)-1:0]                        w_addr_x,
    output logic [$clog2(MAX_KERNEL)-1:0]                        w_addr_y,
    output logic                                                 ren_w,
    input  logic [WEIGHT_DEPTH-1:0]                              rdat_w,
    output logic [$clog2(X_MAX):0]                               x_addr_out,
    output logic [$clog2(Y_MAX):0]                               y_addr_out,
    output logic                                                 wen_out,
    output logic [PIXEL_DEPTH-1:0]                               wdat_out
);

    localparam int KW    = $clog2(MAX_KERNEL);
    localparam int KQW   = $clog2(MAX_KERNEL + 1);   // must hold k = MAX_KERNEL itself
    localparam int IW    = 2 * KQW;
    localparam int XW    = $clog2(X_MAX) + 1;
    localparam int YW    = $clog2(Y_MAX) + 1;
    localparam int ACC_W = acc_width(PIXEL_DEPTH, WEIGHT_DEPTH, MAX_KERNEL);

    state_t           state_q;
    logic [KQW-1:0]   k_q, k_d;
    logic [IW-1:0]    idx_q, idx_last;
    logic [KW-1:0]    xc_q, yc_q;      // weight address counters (current MAC index)
    logic [KW-1:0]    px_q, py_q;      // index whose weight arrives this cycle
    logic             rd_vld_q;        // rdat_w carries a valid weight this cycle
    logic             last_q;
    logic [XW-1:0]    x_addr_q;
    logic [YW-1:0]    y_addr_q;
    logic             new_trans_q, req_q, upd_q, ren_q, wen_q, done_q;
    logic [PIXEL_DEPTH-1:0] sat;
    logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][PIXEL_DEPTH-1:0] window_q;

    // Clamp the requested kernel edge into 1..MAX_KERNEL.
    always_comb begin
        k_d = KQW'(kernel_size);
        if (kernel_size == '0) begin
            k_d = KQW'(1);
        end else if (int'(kernel_size) > MAX_KERNEL) begin
            k_d = KQW'(MAX_KERNEL);
        end
    end

    assign idx_last = IW'(k_q) * IW'(k_q) - IW'(1);

    // Control FSM with registered outputs; counters run alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            idx_q       <= '0;
            xc_q        <= '0;
            yc_q        <= '0;
            px_q        <= '0;
            py_q        <= '0;
            rd_vld_q    <= 1'b0;
            last_q      <= 1'b0;
            x_addr_q    <= '0;
            y_addr_q    <= '0;
            new_trans_q <= 1'b0;
            req_q       <= 1'b0;
            upd_q       <= 1'b0;
            ren_q       <= 1'b0;
            wen_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            // Weight SRAM has one cycle of latency: remember which index was read.
            rd_vld_q <= ren_q;
            px_q     <= xc_q;
            py_q     <= yc_q;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        k_q         <= k_d;
                        new_trans_q <= 1'b1;
                        state_q     <= TRANS;
                    end
                end
                TRANS: begin
                    new_trans_q <= 1'b0;
                    state_q     <= WAIT_RDY;
                end
                WAIT_RDY: begin
                    if (new_sample_ready) begin
                        req_q   <= 1'b1;
                        upd_q   <= 1'b1;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    req_q    <= 1'b0;
                    upd_q    <= 1'b0;
                    x_addr_q <= XW'(curr_x);
                    y_addr_q <= YW'(curr_y);
                    last_q   <= end_pos;
                    idx_q    <= '0;
                    xc_q     <= '0;
                    yc_q     <= '0;
                    ren_q    <= 1'b1;
                    state_q  <= MAC;
                end
                MAC: begin
                    if (idx_q == idx_last) begin
                        ren_q   <= 1'b0;
                        idx_q   <= '0;
                        xc_q    <= '0;
                        yc_q    <= '0;
                        state_q <= DRAIN;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                        if (xc_q == KW'(k_q - 1'b1)) begin
                            xc_q <= '0;
                            yc_q <= yc_q + 1'b1;
                        end else begin
                            xc_q <= xc_q + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    wen_q   <= 1'b1;
                    state_q <= WRITE;
                end
                WRITE: begin
                    wen_q <= 1'b0;
                    if (last_q) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        state_q <= WAIT_RDY;
                    end
                end
                DONE: begin
                    done_q   <= 1'b0;
                    x_addr_q <= '0;
                    y_addr_q <= '0;
                    last_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Snapshot the active k x k corner of the window when the sample is requested.
    always_ff @(posedge clk) begin
        if (rst) begin
            window_q <= '0;
        end else if (state_q == REQ) begin
            for (int x = 0; x < MAX_KERNEL; x++) begin
                for (int y = 0; y < MAX_KERNEL; y++) begin
                    if (x < int'(k_q) && y < int'(k_q)) begin
                        window_q[x][y] <= working_memory[x][y];
                    end
                end
            end
        end
    end

    conv_mac #(
        .PIXEL_DEPTH (PIXEL_DEPTH),
        .WEIGHT_DEPTH(WEIGHT_DEPTH),
        .ACC_W       (ACC_W)
    ) u_mac (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (state_q == REQ),
        .en_i   (rd_vld_q),
        .pix_i  (window_q[px_q][py_q]),
        .wgt_i  (rdat_w),
        .shift_i(norm_shift),
        .sat_o  (sat)
    );

    assign new_trans      = new_trans_q;
    assign new_sample_req = req_q;
    assign update_pos     = upd_q;
    assign ren_w          = ren_q;
    assign w_addr_x       = xc_q;
    assign w_addr_y       = yc_q;
    assign x_addr_out     = x_addr_q;
    assign y_addr_out     = y_addr_q;
    assign wen_out        = wen_q;
    assign wdat_out       = wen_q ? sat : '0;
    assign done           = done_q;

endmodule

// File: tb/tb_gauss_conv_engine.sv
// Self-checking bench for gauss_conv_engine: vector table plus corner sequences,
// with a scoreboard of expected writes filled at each sample request.
module tb_gauss_conv_engine;

    localparam int MK = 31;
    localparam int PD = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [4:0] kernel_size = '0;
    logic [4:0] norm_shift = '0;
    logic done, new_trans, new_sample_req;
    logic new_sample_ready = 1'b0;
    logic [MK-1:0][MK-1:0][PD-1:0] wm;
    logic update_pos;
    logic [5:0] curr_x, curr_y;
    logic end_pos = 1'b0;
    logic [4:0] w_addr_x, w_addr_y;
    logic ren_w;
    logic [7:0] rdat_w;
    logic [6:0] x_addr_out, y_addr_out;
    logic wen_out;
    logic [7:0] wdat_out;

    logic [7:0] wmem [MK][MK];

    typedef struct { int x; int y; int data; int cyc; int lat; } exp_t;
    typedef struct { int ks; int w; int p; int sh; int exp; } vec_t;

    exp_t sbq[$];
    exp_t e, g;
    vec_t tbl[9];

    int cyc = 0;
    int n_cmp = 0, n_fail = 0;
    int keff = 1, exp_fixed = -1, end_at = 1;
    int reqs_n = 0, writes_n = 0, dones_n = 0, trans_n = 0, trans_cyc = 0, start_cyc = 0;

    gauss_conv_engine dut (
        .clk(clk), .rst(rst), .start(start), .kernel_size(kernel_size),
        .norm_shift(norm_shift), .done(done), .new_trans(new_trans),
        .new_sample_req(new_sample_req), .new_sample_ready(new_sample_ready),
        .working_memory(wm), .update_pos(update_pos), .curr_x(curr_x),
        .curr_y(curr_y), .end_pos(end_pos), .w_addr_x(w_addr_x),
        .w_addr_y(w_addr_y), .ren_w(ren_w), .rdat_w(rdat_w),
        .x_addr_out(x_addr_out), .y_addr_out(y_addr_out), .wen_out(wen_out),
        .wdat_out(wdat_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Weight SRAM, one cycle read latency.
    always @(posedge clk) if (ren_w) rdat_w <= wmem[w_addr_x][w_addr_y];

    // Raster position source.
    always @(posedge clk) begin
        if (rst) begin
            curr_x <= '0;
            curr_y <= '0;
        end else if (update_pos) begin
            if (curr_x == 6'd7) begin
                curr_x <= '0;
                curr_y <= curr_y + 6'd1;
            end else begin
                curr_x <= curr_x + 6'd1;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int model();
        int s = 0;
        for (int x = 0; x < keff; x++)
            for (int y = 0; y < keff; y++)
                s += int'(wmem[x][y]) * int'(wm[x][y]);
        s = s >> norm_shift;
        return (s > 255) ? 255 : s;
    endfunction

    task automatic fill(input int wv, input int pv);
        for (int x = 0; x < MK; x++)
            for (int y = 0; y < MK; y++) begin
                wmem[x][y] = 8'(wv);
                wm[x][y]   = 8'(pv);
            end
    endtask

    task automatic fill_rand();
        for (int x = 0; x < MK; x++)
            for (int y = 0; y < MK; y++) begin
                wmem[x][y] = 8'($urandom_range(0, 255));
                wm[x][y]   = 8'($urandom_range(0, 255));
            end
    endtask

    // Monitor: counts pulses, queues expected writes at each request, checks writes.
    always @(negedge clk) begin
        if (rst) begin
            sbq.delete();
        end else begin
            if (new_trans) begin
                trans_n++;
                trans_cyc = cyc;
            end
            if (done) dones_n++;
            if (new_sample_req) begin
                reqs_n++;
                e.x    = int'(curr_x);
                e.y    = int'(curr_y);
                e.data = (exp_fixed >= 0) ? exp_fixed : model();
                e.cyc  = cyc;
                e.lat  = keff * keff + 2;
                sbq.push_back(e);
            end
            end_pos = (reqs_n == end_at);
            if (wen_out) begin
                writes_n++;
                if (sbq.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    g = sbq.pop_front();
                    chk("wdat", wdat_out, g.data);
                    chk("x_addr", x_addr_out, g.x);
                    chk("y_addr", y_addr_out, g.y);
                    chk("req_to_wen", cyc - g.cyc, g.lat);
                end
            end
        end
    end

    task automatic run(input int ks, input int sh, input int ea, input int ef, input bit extra);
        int budget;
        bit pulsed;
        kernel_size = 5'(ks);
        norm_shift  = 5'(sh);
        end_at      = ea;
        exp_fixed   = ef;
        keff        = (ks == 0) ? 1 : ((ks > MK) ? MK : ks);
        reqs_n = 0; writes_n = 0; dones_n = 0; trans_n = 0;
        new_sample_ready = 1'b1;
        @(posedge clk); #1;
        start_cyc = cyc;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        budget = 0;
        pulsed = 1'b0;
        while (dones_n == 0 && budget < 20000) begin
            @(posedge clk); #1;
            budget++;
            if (extra && !pulsed && reqs_n == 2) begin
                start  = 1'b1;
                pulsed = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        chk("done_in_budget", budget < 20000, 1);
        repeat (12) @(posedge clk);
        #1;
        chk("done_pulses", dones_n, 1);
        chk("write_count", writes_n, ea);
        chk("new_trans_count", trans_n, 1);
        chk("start_to_new_trans", trans_cyc - start_cyc, 1);
        chk("sb_empty", sbq.size(), 0);
    endtask

    initial begin
        bit got;
        tbl[0] = '{3, 1, 10, 0, 90};
        tbl[1] = '{3, 255, 255, 0, 255};
        tbl[2] = '{3, 255, 255, 16, 8};
        tbl[3] = '{1, 2, 100, 1, 100};
        tbl[4] = '{2, 3, 7, 2, 21};
        tbl[5] = '{0, 5, 9, 0, 45};
        tbl[6] = '{5, 1, 200, 3, 255};
        tbl[7] = '{31, 1, 1, 2, 240};
        tbl[8] = '{4, 2, 3, 0, 96};
        fill(0, 0);

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("outs_in_reset", {done, new_trans, new_sample_req, update_pos, ren_w, wen_out,
                              w_addr_x, w_addr_y, x_addr_out, y_addr_out, wdat_out}, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("outs_idle", {done, new_trans, new_sample_req, update_pos, ren_w, wen_out,
                          w_addr_x, w_addr_y, x_addr_out, y_addr_out, wdat_out}, 0);

        // Vector table, one position per transaction.
        for (int i = 0; i < 9; i++) begin
            fill(tbl[i].w, tbl[i].p);
            run(tbl[i].ks, tbl[i].sh, 1, tbl[i].exp, 1'b0);
        end

        // Ready held low stalls; reset at MAC index 4 aborts cleanly.
        fill(1, 10);
        kernel_size = 5'd3; norm_shift = 5'd0; keff = 3; exp_fixed = 90; end_at = 1;
        reqs_n = 0; writes_n = 0; dones_n = 0;
        new_sample_ready = 1'b0;
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("no_req_without_ready", reqs_n, 0);
        new_sample_ready = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = new_sample_req;
        end
        chk("req_seen", got, 1);
        repeat (5) @(posedge clk);
        #1;
        chk("mac4_ren", ren_w, 1);
        chk("mac4_addr_x", w_addr_x, 1);
        chk("mac4_addr_y", w_addr_y, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("outs_after_mid_rst", {done, new_trans, new_sample_req, update_pos, ren_w, wen_out,
                                   w_addr_x, w_addr_y, x_addr_out, y_addr_out, wdat_out}, 0);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("no_write_after_rst", writes_n, 0);
        chk("no_done_after_rst", dones_n, 0);
        run(3, 0, 1, 90, 1'b0);

        // Four positions, end at the 4th, extra start while busy.
        fill_rand();
        run(3, 4, 4, -1, 1'b1);
        // Multi-position with a different kernel and no shift.
        fill_rand();
        run(2, 0, 3, -1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
